unidade_load_store: RTL

- Initiator side of the CPU data-memory port: accepts load/store requests from the datapath and drives the memory's `we`/`addr`/`datain`.
- Returns load data from the memory's `dataout`, which is registered with a 1-cycle read latency.
- Memory is word-addressed, 32-bit wide; writes commit on posedge when `we`=1.
- Block adds byte/half/word access with little-endian lane selection and sign/zero extension; sub-word stores use read-modify-write.

---
 rtl/unidade_load_store.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/unidade_load_store.sv
// unidade_load_store: data-memory initiator with byte/half/word lanes.
// Define LSU_ALIGN_CHECK_EN to trap misaligned half/word accesses on err.
module unidade_load_store #(
  parameter int unsigned RAM_SIZE = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] byte_addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
`ifdef LSU_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_datain_q, mem_datain_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  boff_q, boff_d;
  logic [31:0] wdata_q, wdata_d;
  logic        oor_q, oor_d;
`ifdef LSU_ALIGN_CHECK_EN
  logic        err_q, err_d;
  logic        mis;
`endif

  logic        in_oor;
  logic        is_byte;
  logic        is_half;
  logic [4:0]  sh;
  logic [7:0]  b8;
  logic [15:0] h16;
  logic [31:0] ld_val;
  logic [31:0] mask;
  logic [31:0] ins;
  logic [31:0] merged;

  assign in_oor  = {2'b00, byte_addr[31:2]} >= RAM_SIZE;
  assign is_byte = (size_q == 2'b00);
  assign is_half = (size_q == 2'b01);

`ifdef LSU_ALIGN_CHECK_EN
  assign mis = ((size == 2'b01) & byte_addr[0])
             | (size[1] & (|byte_addr[1:0]));
`endif

  // Lane extraction for loads and lane insertion for read-modify-write.
  always_comb begin
    sh     = 5'd0;
    b8     = 8'd0;
    h16    = 16'd0;
    ld_val = mem_dataout;
    mask   = 32'hFFFF_FFFF;
    ins    = wdata_q;
    unique case (1'b1)
      is_byte: begin
        sh     = {boff_q, 3'b000};
        b8     = mem_dataout[sh +: 8];
        ld_val = {{24{sext_q & b8[7]}}, b8};
        mask   = 32'h0000_00FF << sh;
        ins    = {24'd0, wdata_q[7:0]} << sh;
      end
      is_half: begin
        sh     = {boff_q[1], 4'b0000};
        h16    = mem_dataout[sh +: 16];
        ld_val = {{16{sext_q & h16[15]}}, h16};
        mask   = 32'h0000_FFFF << sh;
        ins    = {16'd0, wdata_q[15:0]} << sh;
      end
      default: ;
    endcase
    merged = (mem_dataout & ~mask) | (ins & mask);
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    done_d       = done_q;
    mem_we_d     = mem_we_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sext_d       = sext_q;
    boff_d       = boff_q;
    wdata_d      = wdata_q;
    oor_d        = oor_q;
`ifdef LSU_ALIGN_CHECK_EN
    err_d        = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d       = wr;
          size_d     = size;
          sext_d     = sign_ext;
          boff_d     = byte_addr[1:0];
          wdata_d    = wdata;
          oor_d      = in_oor;
          mem_addr_d = {2'b00, byte_addr[31:2]};
          ready_d    = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
          if (mis) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else
`endif
          if (wr && size[1]) begin
            state_d      = WR;
            mem_datain_d = wdata;
            mem_we_d     = !in_oor;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAP;
      CAP: begin
        if (!wr_q) begin
          state_d = DONE;
          rdata_d = oor_q ? 32'd0 : ld_val;
          done_d  = 1'b1;
        end else begin
          state_d      = WR;
          mem_datain_d = merged;
          mem_we_d     = !oor_q;
        end
      end
      WR: begin
        state_d  = DONE;
        mem_we_d = 1'b0;
        done_d   = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      rdata_q      <= 32'd0;
      mem_addr_q   <= 32'd0;
      mem_datain_q <= 32'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      boff_q       <= 2'b00;
      wdata_q      <= 32'd0;
      oor_q        <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      boff_q       <= boff_d;
      wdata_q      <= wdata_d;
      oor_q        <= oor_d;
`ifdef LSU_ALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign mem_we     = mem_we_q;
  assign rdata      = rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
`ifdef LSU_ALIGN_CHECK_EN
  assign err        = err_q;
`endif

endmodule
